serial_word_tx: RTL and testbench
=================================

Name: serial_word_tx

Overview:
- Upstream feeder for the bit-serial incrementer stage.
- Accepts a parallel NUMBITS-bit word over a valid/ready handshake.
- Emits a one-cycle frame-start pulse, then the word LSB-first, one bit per clock.
- frame_start drives the incrementer's per-frame reset; ser_bit drives its serial input.

Parameters:
- NUMBITS, 4, width of each word and number of serial bits per frame (minimum 2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle; transfer occurs when in_valid && in_ready at a rising edge.
- in_data  input  NUMBITS  parallel word to serialise.
- abort  input  1  synchronous, active-high; drops the current frame.
- frame_start  output  1  one-cycle pulse immediately before bit 0 of a frame.
- ser_bit  output  1  current serial bit, LSB first.
- ser_valid  output  1  ser_bit carries a data bit this cycle.
- ser_last  output  1  ser_bit is bit NUMBITS-1 of the frame.
- busy  output  1  frame in progress (START or SHIFT).

Behaviour:
- States (from the shared package): IDLE, START, SHIFT. Counter cnt is $clog2(NUMBITS) bits wide.
- Reset asserted:
  - State goes to IDLE immediately, independent of clk.
  - Shift register and cnt clear to 0.
  - frame_start, ser_bit, ser_valid, ser_last and busy are all 0.
  - in_ready is forced to 0 while reset is low.
- IDLE:
  - in_ready=1, all other outputs 0.
  - On handshake, latch in_data into the shift register, set cnt=0, go to START.
- START (exactly one cycle):
  - frame_start=1, busy=1, ser_valid=0, ser_bit=0, in_ready=0.
  - Next state is SHIFT.
- SHIFT:
  - ser_valid=1, busy=1, ser_bit=shreg[0].
  - Each edge: shift right by one, cnt++.
  - ser_last=1 when cnt==NUMBITS-1.
  - in_ready=1 only in the ser_last cycle.
- Leaving SHIFT from the ser_last cycle:
  - Handshake in that cycle: latch the new word and go to START (back-to-back).
  - No handshake: go to IDLE.
- Latency and throughput:
  - Handshake at edge k → frame_start high in cycle k+1 → bit i on ser_bit in cycle k+2+i.
  - Back-to-back throughput is one word per NUMBITS+1 cycles, with no idle cycle between frames.
- in_valid while not ready: ignored, and in_data is not sampled. The upstream holds the word, and it is taken at the next ready cycle.
- abort:
  - Highest priority after reset. When abort=1, in_ready is forced to 0, so no handshake can occur that cycle.
  - Next edge: state goes to IDLE and cnt clears.
  - No further ser_valid bits are emitted for the dropped frame.
  - abort in IDLE has no effect other than the suppressed handshake.
- Reset mid-frame: the frame is lost. After release the block sits in IDLE, with no ser_valid until a new handshake.
- Data values: all 2^NUMBITS words are legal, and the word is transmitted unchanged. No arithmetic is performed here.
- Output timing: all outputs except in_ready decode directly from registered state. in_ready is combinational from state, cnt, abort and reset.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum (IDLE, START, SHIFT);
  - the default NUMBITS constant;
  - the counter-width function based on $clog2.
- One natural sub-module: piso_shift_reg.
  - Function: parallel load, shift-right enable, asynchronous active-low clear, serial LSB output.
  - Parameterised by NUMBITS.
- The control FSM and cnt stay in serial_word_tx.

Test Plan:
- Reset release, then in_data=4'b1011 with in_valid for one cycle:
  - frame_start pulses once on the next cycle.
  - ser_bit is 1,1,0,1 over four consecutive ser_valid cycles.
  - ser_last accompanies the 4th bit.
  - in_ready returns to 1 afterwards.
- Back-to-back words 4'h3 then 4'hC with in_valid held high:
  - The second handshake occurs in the ser_last cycle of the first frame.
  - frame_start for 4'hC appears on the very next cycle.
  - The serial stream is 1,1,0,0 then 0,0,1,1.
- in_valid asserted with 4'h9 during START and early SHIFT:
  - in_ready stays 0 and the word is not taken.
  - The word is accepted exactly in the ser_last cycle.
- Reset asserted asynchronously after 2 bits of 4'hF:
  - All outputs drop to 0 without waiting for a clock edge.
  - After release there is no ser_valid until a new handshake.
- abort high during the START cycle of 4'h6:
  - Next cycle is IDLE with ser_valid=0 throughout.
  - Simultaneous in_valid is not accepted.
- End-to-end with the bit-serial incrementer for all 16 words (frame_start→its reset, ser_bit→its input):
  - The collected output equals (in_data+1) mod 16.
  - Include 4'hF→4'h0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial word path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_pkg;

  // Default frame width, matching the downstream 4-bit serial incrementer.
  localparam int NUMBITS_DEF = 4;

  // Encodings kept as plain constants so older blocks can compare raw bits.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    SHIFT = ST_SHIFT
  } state_t;

  // Bit-counter width for a frame of nbits bits; never narrower than 1.
  function automatic int cnt_width(input int nbits);
    return (nbits < 2) ? 1 : $clog2(nbits);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB emitted first.
// Latency: load/shift take effect on the next rising edge.
// Backpressure: none; the owner decides when to load or shift.
module piso_shift_reg
  import serial_pkg::*;
#(
  parameter int NUMBITS = NUMBITS_DEF
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               load,
  input  logic [NUMBITS-1:0] load_data,
  input  logic               shift_en,
  output logic               ser_out
);

  logic [NUMBITS-1:0] shreg;

  // Load has priority so a back-to-back word replaces the drained one.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift_en) begin
      shreg <= {1'b0, shreg[NUMBITS-1:1]};
    end
  end

  assign ser_out = shreg[0];

endmodule

// File: rtl/serial_word_tx.sv
// Serialises a parallel word: one frame_start cycle, then NUMBITS bits LSB-first.
// Latency: handshake at edge k -> frame_start in cycle k+1 -> bit i in cycle k+2+i.
// Backpressure: in_ready only in IDLE or the last-bit cycle; abort and reset force it low.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int NUMBITS = NUMBITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] in_data,
  input  logic               abort,
  output logic               frame_start,
  output logic               ser_bit,
  output logic               ser_valid,
  output logic               ser_last,
  output logic               busy
);

  localparam int CW = cnt_width(NUMBITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUMBITS - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          at_last;
  logic          in_shift;
  logic          hs;
  logic          sh_lsb;

  assign in_shift = (state == SHIFT);
  assign at_last  = in_shift && (cnt == CNT_LAST);

  // Ready is the only combinational output: a new word may enter while idle or
  // while the final bit of the current word is on the line.
  assign in_ready = reset && !abort && ((state == IDLE) || at_last);
  assign hs       = in_valid && in_ready;

  piso_shift_reg #(
    .NUMBITS (NUMBITS)
  ) u_piso (
    .clk       (clk),
    .clr_n     (reset),
    .load      (hs),
    .load_data (in_data),
    .shift_en  (in_shift && !abort),
    .ser_out   (sh_lsb)
  );

  // Next-state and bit-counter selection; abort drops the frame outright.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end
        START: begin
          state_nxt = SHIFT;
        end
        SHIFT: begin
          if (at_last) begin
            cnt_nxt   = '0;
            state_nxt = hs ? START : IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Control state; reset returns to IDLE without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Frame-side outputs decode straight from registered state.
  assign frame_start = (state == START);
  assign ser_valid   = in_shift;
  assign ser_bit     = in_shift && sh_lsb;
  assign ser_last    = at_last;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_serial_word_tx.sv
// Randomised and directed bench for serial_word_tx with a frame-timing model.
// Latency: model expects frame_start one cycle after a handshake, bits after that.
// Backpressure: model decides readiness from its own frame bookkeeping.
module tb_serial_word_tx;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         abort = 1'b0;
  logic         frame_start;
  logic         ser_bit;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Reference model: when the accepted frame started and what it carries.
  int           cyc = 0;
  int           start_c = 0;
  logic         act = 1'b0;
  logic [N-1:0] word = '0;
  logic [N-1:0] inc_exp = '0;

  // Behavioural bit-serial incrementer fed from the DUT outputs.
  logic         inc_carry = 1'b0;
  int           inc_idx = 0;
  logic [N-1:0] inc_acc = '0;
  logic [N-1:0] raw_acc = '0;
  int           done_cnt = 0;

  serial_word_tx #(.NUMBITS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .abort       (abort),
    .frame_start (frame_start),
    .ser_bit     (ser_bit),
    .ser_valid   (ser_valid),
    .ser_last    (ser_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check at negedge, advance model at posedge.
  task automatic step(input logic v, input logic [N-1:0] d, input logic ab, output logic hs);
    logic e_fs, e_sv, e_bit, e_last, e_rdy;
    int   bi;
    in_valid = v;
    in_data  = d;
    abort    = ab;
    @(negedge clk);
    e_fs   = act && (cyc == start_c);
    e_sv   = act && (cyc > start_c) && (cyc <= start_c + N);
    bi     = cyc - start_c - 1;
    e_bit  = e_sv ? word[bi] : 1'b0;
    e_last = e_sv && (cyc == start_c + N);
    e_rdy  = !ab && (!act || e_last);
    check_eq("frame_start", frame_start, e_fs);
    check_eq("ser_valid", ser_valid, e_sv);
    check_eq("ser_bit", ser_bit, e_bit);
    check_eq("ser_last", ser_last, e_last);
    check_eq("busy", busy, act);
    check_eq("in_ready", in_ready, e_rdy);
    if (frame_start) begin
      inc_carry = 1'b1;
      inc_idx   = 0;
      inc_acc   = '0;
      raw_acc   = '0;
    end
    if (ser_valid && inc_idx < N) begin
      inc_acc[inc_idx] = ser_bit ^ inc_carry;
      raw_acc[inc_idx] = ser_bit;
      inc_carry        = inc_carry & ser_bit;
      inc_idx++;
      if (ser_last) begin
        check_eq("raw_word", raw_acc, word);
        check_eq("inc_word", inc_acc, inc_exp);
        done_cnt++;
      end
    end
    @(posedge clk);
    hs = e_rdy && v;
    if (hs) begin
      act     = 1'b1;
      start_c = cyc + 1;
      word    = d;
      inc_exp = N'((32'(d) + 1) % (1 << N));
    end else if (ab || e_last) begin
      act = 1'b0;
    end
    cyc++;
    #1;
  endtask

  // Hold in_valid with d until the model sees a handshake; n counts the steps.
  task automatic send_until_hs(input logic [N-1:0] d, output int n);
    logic hs;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 20) begin
      step(1'b1, d, 1'b0, hs);
      n++;
    end
    if (!hs) check_eq("hs_timeout", 32'(n), 32'(0));
  endtask

  task automatic idle(input int cycles);
    logic hs;
    for (int i = 0; i < cycles; i++) step(1'b0, N'($urandom), 1'b0, hs);
  endtask

  initial begin
    logic hs;
    int   n;
    int   d0;

    // Reset held: everything low, in_ready forced off despite in_valid.
    in_valid = 1'b1;
    #12;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ser_valid", ser_valid, 0);
    check_eq("rst_frame_start", frame_start, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single word 1011: bits 1,1,0,1 then back to ready.
    step(1'b1, 4'hB, 1'b0, hs);
    check_eq("t1_hs", hs, 1);
    idle(6);

    // Back-to-back 3 then C with in_valid held high.
    send_until_hs(4'h3, n);
    send_until_hs(4'hC, n);
    check_eq("b2b_gap", 32'(n), 32'(N + 1));
    idle(6);

    // Word 9 offered from START onward is only taken in the last-bit cycle.
    send_until_hs(4'h2, n);
    send_until_hs(4'h9, n);
    check_eq("hold9_gap", 32'(n), 32'(N + 1));
    idle(6);

    // Asynchronous reset after two bits of F.
    send_until_hs(4'hF, n);
    idle(3);
    #2;
    in_valid = 1'b1;
    reset    = 1'b0;
    #1;
    check_eq("arst_ser_valid", ser_valid, 0);
    check_eq("arst_ser_bit", ser_bit, 0);
    check_eq("arst_ser_last", ser_last, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_frame_start", frame_start, 0);
    check_eq("arst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    act      = 1'b0;
    @(posedge clk);
    #1;
    idle(5);

    // Abort during START of 6 with in_valid also high.
    send_until_hs(4'h6, n);
    step(1'b1, 4'h6, 1'b1, hs);
    check_eq("abort_hs", hs, 0);
    idle(6);

    // End to end through the incrementer for every word.
    d0 = done_cnt;
    for (int w = 0; w < (1 << N); w++) begin
      send_until_hs(N'(w), n);
      idle(N + 1);
    end
    check_eq("e2e_frames", 32'(done_cnt - d0), 32'(1 << N));

    // Random traffic with occasional aborts.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), N'($urandom), ($urandom_range(0, 19) == 0), hs);
    end
    idle(N + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus thread stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
